// File: rtl/cpu_defs.sv
// cpu_defs: shared parameters and refill state encoding for the instruction-cache refill engine
package cpu_defs;
    localparam int ADDR_WIDTH_DEF  = 17;
    localparam int BLOCK_WIDTH_DEF = 4;
    localparam int BLOCK_SIZE_DEF  = 2 ** BLOCK_WIDTH_DEF;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } refill_state_e;
endpackage

// File: rtl/line_assembler.sv
// line_assembler: tracks the byte in flight and writes it into its lane of the line buffer
module line_assembler
    import cpu_defs::*;
#(
    parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEF,
    parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue,
    input  logic                    clear,
    input  logic [BLOCK_WIDTH-1:0]  issue_idx,
    input  logic [7:0]              data_in,
    output logic [BLOCK_SIZE*8-1:0] line_next
);
    logic                    pend_q, pend_d;
    logic [BLOCK_WIDTH-1:0]  pend_idx_q, pend_idx_d;
    logic [BLOCK_SIZE*8-1:0] buf_q, buf_d;
    always_comb begin
        pend_d     = issue && !clear;
        pend_idx_d = issue ? issue_idx : pend_idx_q;
        for (int i = 0; i < BLOCK_SIZE; i++)
            buf_d[8*i +: 8] = (pend_q && pend_idx_q == BLOCK_WIDTH'(i)) ? data_in : buf_q[8*i +: 8];
    end
    assign line_next = buf_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q     <= 1'b0;
            pend_idx_q <= '0;
            buf_q      <= '0;
        end else begin
            pend_q     <= pend_d;
            pend_idx_q <= pend_idx_d;
            buf_q      <= buf_d;
        end
    end
endmodule

// File: rtl/icache_refill.sv
// icache_refill: reads one cache line byte-by-byte from RAM and returns it as a one-cycle pulse.
// Optional ICACHE_REFILL_FLUSH_EN adds a flush input that abandons the refill in progress.
module icache_refill
    import cpu_defs::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int BLOCK_WIDTH = BLOCK_WIDTH_DEF,
    parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
    input  logic                              clkIn,
    input  logic                              resetIn,
`ifdef ICACHE_REFILL_FLUSH_EN
    input  logic                              flush,
`endif
    input  logic                              missValid,
    input  logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] missAddr,
    output logic                              busy,
    output logic                              ramRead,
    output logic [ADDR_WIDTH-1:0]             ramAddr,
    input  logic [7:0]                        ramDataIn,
    input  logic                              ramStall,
    output logic                              lineValid,
    output logic [ADDR_WIDTH-BLOCK_WIDTH-1:0] lineAddr,
    output logic [BLOCK_SIZE*8-1:0]           lineData
);
    localparam int LW = ADDR_WIDTH - BLOCK_WIDTH;
    refill_state_e           state_q, state_d;
    logic [BLOCK_WIDTH-1:0]  cnt_q, cnt_d;
    logic [LW-1:0]           line_q, line_d;
    logic                    busy_q, busy_d;
    logic                    ram_read_q, ram_read_d;
    logic [ADDR_WIDTH-1:0]   ram_addr_q, ram_addr_d;
    logic                    line_valid_q, line_valid_d;
    logic [LW-1:0]           line_addr_q, line_addr_d;
    logic [BLOCK_SIZE*8-1:0] line_data_q, line_data_d;
    logic [BLOCK_SIZE*8-1:0] line_next;
    logic                    issue, flush_w;
`ifdef ICACHE_REFILL_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif
    assign issue = (state_q == FETCH) && !ramStall;
    line_assembler #(.BLOCK_WIDTH(BLOCK_WIDTH), .BLOCK_SIZE(BLOCK_SIZE)) u_asm (
        .clk       (clkIn),
        .rst       (resetIn),
        .issue     (issue),
        .clear     (flush_w),
        .issue_idx (cnt_q),
        .data_in   (ramDataIn),
        .line_next (line_next)
    );
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_d       = line_q;
        busy_d       = busy_q;
        ram_read_d   = ram_read_q;
        ram_addr_d   = ram_addr_q;
        line_valid_d = 1'b0;
        line_addr_d  = line_addr_q;
        line_data_d  = line_data_q;
        case (state_q)
            IDLE: if (missValid) begin
                state_d    = FETCH;
                line_d     = missAddr;
                cnt_d      = '0;
                ram_addr_d = {missAddr, {BLOCK_WIDTH{1'b0}}};
                ram_read_d = 1'b1;
                busy_d     = 1'b1;
            end
            FETCH: if (issue) begin
                cnt_d      = cnt_q + 1'b1;
                ram_addr_d = {line_q, cnt_d};
                ram_read_d = cnt_q != '1;
                state_d    = cnt_q == '1 ? DRAIN : FETCH;
            end
            DRAIN: begin
                state_d      = DONE;
                line_valid_d = 1'b1;
                line_addr_d  = line_q;
                line_data_d  = line_next;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
        // flush overrides everything, including a miss arriving in the same cycle
        if (flush_w) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            ram_read_d   = 1'b0;
            line_valid_d = 1'b0;
            line_addr_d  = line_addr_q;
            line_data_d  = line_data_q;
        end
    end
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            line_q       <= '0;
            busy_q       <= 1'b0;
            ram_read_q   <= 1'b0;
            ram_addr_q   <= '0;
            line_valid_q <= 1'b0;
            line_addr_q  <= '0;
            line_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            line_q       <= line_d;
            busy_q       <= busy_d;
            ram_read_q   <= ram_read_d;
            ram_addr_q   <= ram_addr_d;
            line_valid_q <= line_valid_d;
            line_addr_q  <= line_addr_d;
            line_data_q  <= line_data_d;
        end
    end
    assign busy      = busy_q;
    assign ramRead   = ram_read_q;
    assign ramAddr   = ram_addr_q;
    assign lineValid = line_valid_q;
    assign lineAddr  = line_addr_q;
    assign lineData  = line_data_q;
endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed bench for icache_refill with a scoreboard of expected returned lines
module tb_icache_refill;
    logic         clk = 1'b0;
    logic         resetIn, missValid, ramStall;
    logic [12:0]  missAddr;
    logic         busy, ramRead, lineValid;
    logic [16:0]  ramAddr;
    logic [7:0]   ramDataIn = 8'hEE;
    logic [12:0]  lineAddr;
    logic [127:0] lineData;
`ifdef ICACHE_REFILL_FLUSH_EN
    logic         flush = 1'b0;
`endif
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    typedef struct {
        logic [12:0]  a;
        logic [127:0] d;
        int           c;
    } exp_t;
    exp_t sb[$];

    icache_refill dut (
        .clkIn     (clk),
        .resetIn   (resetIn),
`ifdef ICACHE_REFILL_FLUSH_EN
        .flush     (flush),
`endif
        .missValid (missValid),
        .missAddr  (missAddr),
        .busy      (busy),
        .ramRead   (ramRead),
        .ramAddr   (ramAddr),
        .ramDataIn (ramDataIn),
        .ramStall  (ramStall),
        .lineValid (lineValid),
        .lineAddr  (lineAddr),
        .lineData  (lineData)
    );

    always #5 clk = ~clk;
    // cyc = number of rising edges seen; read at the falling edge
    always @(posedge clk) cyc <= cyc + 1;
    // RAM returns byte a[7:0] the cycle after a taken issue, junk otherwise
    always @(posedge clk) ramDataIn <= (ramRead && !ramStall) ? ramAddr[7:0] : 8'hEE;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] exp_line(input logic [12:0] a);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = {a[3:0], i[3:0]};
        return r;
    endfunction

    task automatic tick();
        @(negedge clk);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (lineValid) begin
            if (sb.size() == 0) chk("spurious_line_valid", lineValid, 1'b0);
            else begin
                e = sb.pop_front();
                chk("line_addr", lineAddr, e.a);
                chk("line_data", lineData, e.d);
                chk("line_cycle", cyc, e.c);
            end
        end
    end

    // accepted at edge t; lineValid is visible after edge t+17 (+ stall cycles)
    task automatic start_miss(input logic [12:0] a, input int stalls, input bit hold, output int t);
        missAddr = a;
        missValid = 1'b1;
        tick();
        t = cyc;
        missValid = hold;
        sb.push_back('{a, exp_line(a), t + 17 + stalls});
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 60) begin
            tick();
            n++;
        end
        chk("idle_timeout", busy, 1'b0);
    endtask

    task automatic run_clean(input logic [12:0] a, input bit stall_drain);
        int t;
        start_miss(a, 0, 1'b0, t);
        chk("busy_fetch", busy, 1'b1);
        for (int j = 0; j < 16; j++) begin
            chk("ram_addr", ramAddr, {a, 4'(j)});
            chk("ram_read", ramRead, 1'b1);
            tick();
        end
        chk("drain_read", ramRead, 1'b0);
        chk("drain_busy", busy, 1'b1);
        ramStall = stall_drain;
        tick();
        ramStall = 1'b0;
        chk("done_busy", busy, 1'b1);
        tick();
        chk("line_valid_drop", lineValid, 1'b0);
        chk("busy_idle", busy, 1'b0);
        chk("line_data_hold", lineData, exp_line(a));
    endtask

    initial begin
        int t;
        resetIn = 1'b1;
        missValid = 1'b0;
        ramStall = 1'b0;
        missAddr = '0;
        repeat (3) tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_ram_read", ramRead, 1'b0);
        chk("rst_ram_addr", ramAddr, 17'h0);
        chk("rst_line_valid", lineValid, 1'b0);
        chk("rst_line_addr", lineAddr, 13'h0);
        chk("rst_line_data", lineData, 128'h0);
        resetIn = 1'b0;
        tick();

        run_clean(13'h0123, 1'b0);
        tick();

        start_miss(13'h0123, 3, 1'b0, t);
        tick();
        tick();
        chk("stall_addr_pre", ramAddr, 17'h01232);
        ramStall = 1'b1;
        repeat (2) begin
            tick();
            chk("stall_addr_hold", ramAddr, 17'h01232);
        end
        tick();
        ramStall = 1'b0;
        chk("stall_addr_last", ramAddr, 17'h01232);
        tick();
        chk("stall_addr_resume", ramAddr, 17'h01233);
        wait_idle();
        tick();

        start_miss(13'h0042, 0, 1'b1, t);
        sb.push_back('{13'h0042, exp_line(13'h0042), t + 19 + 17});
        while (cyc < t + 18) tick();
        chk("done_miss_ignored", busy, 1'b0);
        tick();
        chk("reaccept_after_idle", busy, 1'b1);
        missValid = 1'b0;
        wait_idle();
        repeat (3) tick();

        run_clean(13'h1FFF, 1'b1);
        tick();

        missAddr = 13'h0777;
        missValid = 1'b1;
        tick();
        missValid = 1'b0;
        repeat (7) tick();
        chk("pre_reset_addr", ramAddr, 17'h07777);
        #2 resetIn = 1'b1;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_ram_read", ramRead, 1'b0);
        chk("arst_ram_addr", ramAddr, 17'h0);
        chk("arst_line_addr", lineAddr, 13'h0);
        chk("arst_line_data", lineData, 128'h0);
        tick();
        tick();
        resetIn = 1'b0;
        repeat (25) tick();
        chk("arst_still_idle", busy, 1'b0);
        run_clean(13'h0ABC, 1'b0);
        tick();

`ifdef ICACHE_REFILL_FLUSH_EN
        missAddr = 13'h0555;
        missValid = 1'b1;
        tick();
        missValid = 1'b0;
        t = cyc;
        while (cyc < t + 8) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("flush_busy", busy, 1'b0);
        chk("flush_ram_read", ramRead, 1'b0);
        repeat (25) tick();
        flush = 1'b1;
        missValid = 1'b1;
        tick();
        flush = 1'b0;
        missValid = 1'b0;
        chk("flush_beats_miss", busy, 1'b0);
        tick();
        run_clean(13'h0321, 1'b0);
`endif
        repeat (3) tick();
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- Memory-side refill engine for the instruction cache. Responds to a cache miss by reading one cache line byte-by-byte from the byte-wide RAM port.
- Assembles the line little-endian and returns it to the cache as a one-cycle line-valid pulse, with the line address and 128-bit data.
- Sits between the instruction cache's miss output and the RAM (or RAM arbiter) read port.

Parameters:
- ADDR_WIDTH, 17, byte address width of RAM.
- BLOCK_WIDTH, 4, log2 of line size in bytes.
- BLOCK_SIZE, 2**BLOCK_WIDTH, line size in bytes (16).

Ports:
- clkIn  input  1  system clock.
- resetIn  input  1  asynchronous, active-high reset.
- missValid  input  1  cache requests a refill of line missAddr.
- missAddr  input  ADDR_WIDTH-BLOCK_WIDTH  line address (byte address bits [ADDR_WIDTH-1:BLOCK_WIDTH]).
- busy  output  1  refill in progress; new misses are not accepted.
- ramRead  output  1  read strobe, one byte per non-stalled cycle.
- ramAddr  output  ADDR_WIDTH  byte address being read.
- ramDataIn  input  8  read data, valid the cycle after a non-stalled issue.
- ramStall  input  1  RAM/arbiter not ready; the current issue is not taken.
- lineValid  output  1  one-cycle pulse: line returned.
- lineAddr  output  ADDR_WIDTH-BLOCK_WIDTH  address of the returned line.
- lineData  output  BLOCK_SIZE*8  returned line; byte i in bits [8i+7:8i].

Behaviour:
- All outputs are registered.
- Reset (async, active-high):
  - state=IDLE.
  - busy=0, ramRead=0, ramAddr=0.
  - lineValid=0, lineAddr=0, lineData=0.
  - issue counter=0; pending flag=0.
- States:
  - IDLE: busy=0. missValid=1 at an edge → latch missAddr, go to FETCH, set ramAddr={missAddr,0}, ramRead=1, busy=1.
  - FETCH: each cycle with ramStall=0 is an issue of byte index k (counter) at ramAddr.
    - After an issue: counter increments, ramAddr increments. pending=1 with pendIdx=k.
    - With ramStall=1: ramAddr, ramRead and counter hold; pending=0 for the next cycle.
    - Byte capture: any cycle with pending=1 captures ramDataIn into byte pendIdx of the line buffer.
    - After the issue of byte BLOCK_SIZE-1 → ramRead=0, go to DRAIN.
  - DRAIN: captures the last byte → DONE, lineValid=1, lineAddr=latched address, lineData=buffer.
  - DONE: lineValid held exactly one cycle → IDLE, lineValid=0, busy=0.
- Latency with no stalls:
  - missValid sampled at edge T; issues occur in cycles T+1..T+16; DRAIN is cycle T+17.
  - lineValid=1 in cycle T+18.
  - Each stall cycle adds exactly one cycle.
- Boundaries:
  - missValid while busy=1 is ignored, and is never queued. The cache keeps asserting the miss until it sees lineValid.
  - missValid in the DONE cycle is ignored; it is accepted once IDLE is reached.
  - The counter is BLOCK_WIDTH bits and never wraps into the next line. ramAddr stays within the line: {line, counter}.
  - Line address at maximum ({ADDR_WIDTH-BLOCK_WIDTH{1}}) works with no overflow.
  - ramStall during DRAIN has no effect (no issue pending).
  - lineData remains stable after DONE until the next DRAIN capture.
- Reset mid-refill aborts immediately.
  - No lineValid is produced.
  - Late ramDataIn is ignored.

Optional Feature:
- Macro ICACHE_REFILL_FLUSH_EN.
- Defined: adds input flush (1 bit), used for branch mispredict or clear.
  - flush=1 at an edge in any state → IDLE, ramRead=0, busy=0, pending=0.
  - lineValid is not asserted; a DONE-cycle pulse already visible is unaffected.
  - flush and missValid together in IDLE → flush wins; the miss is not accepted.
- Undefined: no port; every accepted refill completes.

Decomposition:
- Shared package (cpu_defs):
  - ADDR_WIDTH, BLOCK_WIDTH, BLOCK_SIZE defaults.
  - Refill state encoding localparams: IDLE=2'd0, FETCH=2'd1, DRAIN=2'd2, DONE=2'd3.
- One natural sub-module: line_assembler (pending flag, pendIdx, byte-lane write into the BLOCK_SIZE*8 buffer). The FSM and address counter stay in the top module.

Test Plan:
- Reset, then a single miss with missAddr=0x0123 and RAM byte at address a = a[7:0] → ramAddr 0x1230..0x123F; lineValid 1 cycle at T+18; lineData=0x3F3E...3130; lineAddr=0x0123.
- Same miss with ramStall=1 for cycles T+3..T+5 → ramAddr holds at 0x1232 for 3 cycles; lineValid at T+21; lineData unchanged from the no-stall case.
- missValid held high continuously, including during DONE → exactly one refill per line; second acceptance on the edge after DONE (IDLE); no duplicate lineValid.
- missAddr=0x1FFF (top line) → ramAddr 0x1FFF0..0x1FFFF; no wrap to 0x00000; correct data.
- resetIn asserted asynchronously mid-FETCH (after 7 bytes) → outputs go to zero immediately; no lineValid; next miss completes normally.
- With ICACHE_REFILL_FLUSH_EN: flush at T+9 → busy=0 and ramRead=0 next cycle; no lineValid; flush+missValid together in IDLE → not accepted.
